// File: rtl/ltc2333_read_if.sv
// Output word stream of the LTC2333 read path (master = reader, slave = consumer).
// Latency: none, plain wires grouped for port use.
// Backpressure: slave holds m_ready low to stall; master keeps the word stable until accepted.
interface ltc2333_read_if;
   logic        m_valid;
   logic        m_ready;
   logic [17:0] m_data;
   logic [2:0]  m_channel;
   logic [2:0]  m_softspan;
   logic        m_last;

   modport master (
      output m_valid, m_data, m_channel, m_softspan, m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid, m_data, m_channel, m_softspan, m_last,
      output m_ready
   );
endinterface

// File: rtl/ltc2333_read.sv
// LTC2333 serial read capture: deserializes echoed-clock sdo into 24-bit words per cnv frame.
// Latency: word presented one clk after the synchronized completing scko rise (SYNC_STAGES+2 clk from pin).
// Backpressure: single output register; a word completing while the previous one is unaccepted is dropped and flagged.
module ltc2333_read #(
   parameter int NUM_WORDS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           aresetn,
   input  logic           cnv,
   input  logic           scko,
   input  logic           sdo,
   input  logic           clear_flags,
   output logic           overflow,
   output logic           frame_error,
   ltc2333_read_if.master m_if
);
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);
   // Edge detection stays disabled until the synchronizers and history have been refilled
   // after reset, so a level already high at release never looks like a rise.
   localparam logic [2:0] ARM_CNT  = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] cnv_sync_q, cnv_sync_d;
   logic [SYNC_STAGES-1:0] scko_sync_q, scko_sync_d;
   logic [SYNC_STAGES-1:0] sdo_sync_q, sdo_sync_d;
   logic                   cnv_prev_q, cnv_prev_d;
   logic                   scko_prev_q, scko_prev_d;
   logic [2:0]             arm_cnt_q, arm_cnt_d;
   state_t                 state_q, state_d;
   logic [4:0]             bit_cnt_q, bit_cnt_d;
   logic [2:0]             word_cnt_q, word_cnt_d;
   logic [23:0]            sr_q, sr_d;
   logic                   done_q, done_d;
   logic                   done_last_q, done_last_d;
   logic                   m_valid_q, m_valid_d;
   logic                   m_last_q, m_last_d;
   logic [17:0]            m_data_q, m_data_d;
   logic [2:0]             m_channel_q, m_channel_d;
   logic [2:0]             m_softspan_q, m_softspan_d;
   logic                   overflow_q, overflow_d;
   logic                   frame_error_q, frame_error_d;

   logic cnv_s, scko_s, sdo_s, armed;
   logic cnv_rise, scko_rise, word_end, final_end;
   logic ovf_set, fe_set;

   assign cnv_s     = cnv_sync_q[SYNC_STAGES-1];
   assign scko_s    = scko_sync_q[SYNC_STAGES-1];
   assign sdo_s     = sdo_sync_q[SYNC_STAGES-1];
   assign armed     = (arm_cnt_q == ARM_CNT);
   assign cnv_rise  = armed & cnv_s & ~cnv_prev_q;
   assign scko_rise = armed & scko_s & ~scko_prev_q;
   assign word_end  = scko_rise & (bit_cnt_q == 5'd23);
   assign final_end = word_end & (word_cnt_q == LAST_IDX);

   // Next-state: synchronizers, frame FSM, output register load/accept, sticky flags.
   always_comb begin
      cnv_sync_d   = {cnv_sync_q[SYNC_STAGES-2:0], cnv};
      scko_sync_d  = {scko_sync_q[SYNC_STAGES-2:0], scko};
      sdo_sync_d   = {sdo_sync_q[SYNC_STAGES-2:0], sdo};
      cnv_prev_d   = cnv_s;
      scko_prev_d  = scko_s;
      arm_cnt_d    = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      sr_d         = sr_q;
      done_d       = 1'b0;
      done_last_d  = 1'b0;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      m_data_d     = m_data_q;
      m_channel_d  = m_channel_q;
      m_softspan_d = m_softspan_q;
      ovf_set      = 1'b0;
      fe_set       = 1'b0;

      case (state_q)
         IDLE: begin
            if (cnv_rise) begin
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               state_d    = SHIFT;
            end
         end
         default: begin
            // A cnv rise landing exactly on the final word's completion is a clean back-to-back frame.
            if (cnv_rise && !final_end) begin
               fe_set     = 1'b1;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
            end else if (scko_rise) begin
               sr_d = {sr_q[22:0], sdo_s};
               if (word_end) begin
                  bit_cnt_d   = '0;
                  word_cnt_d  = word_cnt_q + 3'd1;
                  done_d      = 1'b1;
                  done_last_d = (word_cnt_q == LAST_IDX);
                  if (final_end) begin
                     word_cnt_d = '0;
                     state_d    = cnv_rise ? SHIFT : IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
      endcase

      if (m_valid_q && m_if.m_ready) begin
         m_valid_d = 1'b0;
      end
      if (done_q) begin
         if (!m_valid_q || m_if.m_ready) begin
            m_valid_d    = 1'b1;
            m_data_d     = sr_q[23:6];
            m_channel_d  = sr_q[5:3];
            m_softspan_d = sr_q[2:0];
            m_last_d     = done_last_q;
         end else begin
            ovf_set = 1'b1;
         end
      end

      overflow_d    = (overflow_q & ~clear_flags) | ovf_set;
      frame_error_d = (frame_error_q & ~clear_flags) | fe_set;
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         cnv_sync_q    <= '0;
         scko_sync_q   <= '0;
         sdo_sync_q    <= '0;
         cnv_prev_q    <= 1'b0;
         scko_prev_q   <= 1'b0;
         arm_cnt_q     <= '0;
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         word_cnt_q    <= '0;
         sr_q          <= '0;
         done_q        <= 1'b0;
         done_last_q   <= 1'b0;
         m_valid_q     <= 1'b0;
         m_last_q      <= 1'b0;
         m_data_q      <= '0;
         m_channel_q   <= '0;
         m_softspan_q  <= '0;
         overflow_q    <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         cnv_sync_q    <= cnv_sync_d;
         scko_sync_q   <= scko_sync_d;
         sdo_sync_q    <= sdo_sync_d;
         cnv_prev_q    <= cnv_prev_d;
         scko_prev_q   <= scko_prev_d;
         arm_cnt_q     <= arm_cnt_d;
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         word_cnt_q    <= word_cnt_d;
         sr_q          <= sr_d;
         done_q        <= done_d;
         done_last_q   <= done_last_d;
         m_valid_q     <= m_valid_d;
         m_last_q      <= m_last_d;
         m_data_q      <= m_data_d;
         m_channel_q   <= m_channel_d;
         m_softspan_q  <= m_softspan_d;
         overflow_q    <= overflow_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign m_if.m_valid    = m_valid_q;
   assign m_if.m_last     = m_last_q;
   assign m_if.m_data     = m_data_q;
   assign m_if.m_channel  = m_channel_q;
   assign m_if.m_softspan = m_softspan_q;
   assign overflow        = overflow_q;
   assign frame_error     = frame_error_q;
endmodule

// File: tb/tb_ltc2333_read.sv
// Bench for ltc2333_read: table-driven frames, directed corner sequences, randomized frames vs a word-level model.
// Latency: inputs driven 2 time units after the rising edge, outputs sampled on the falling edge.
// Backpressure: m_ready driven directly or by a random process; accepted words captured into got_q.
module tb_ltc2333_read;
   logic clk = 1'b0;
   logic aresetn, cnv, scko, sdo, clear_flags;
   logic overflow, frame_error;

   ltc2333_read_if bus();

   ltc2333_read #(.NUM_WORDS(8), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .cnv         (cnv),
      .scko        (scko),
      .sdo         (sdo),
      .clear_flags (clear_flags),
      .overflow    (overflow),
      .frame_error (frame_error),
      .m_if        (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [17:0] d;
      logic [2:0]  ch;
      logic [2:0]  sp;
      logic        last;
   } out_t;

   typedef struct {
      logic [23:0] word;
      out_t        exp;
   } vec_t;

   out_t got_q[$];
   out_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   stab_err = 0;
   int   vld_low  = 0;
   bit   watch    = 1'b0;
   bit   rnd_rdy  = 1'b0;

   function automatic out_t mk(input logic [17:0] d, input logic [2:0] c,
                               input logic [2:0] s, input logic l);
      return {d, c, s, l};
   endfunction

   function automatic out_t cur_out();
      return {bus.m_data, bus.m_channel, bus.m_softspan, bus.m_last};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0; cnv = 1'b0; scko = 1'b0; sdo = 1'b0; clear_flags = 1'b0;
      step(3);
      aresetn = 1'b1;
      step(6);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic pulse_cnv();
      scko = 1'b0;
      cnv  = 1'b1;
      step(2);
      cnv  = 1'b0;
      step(2);
   endtask

   // MSB-first bits; sdo changes while scko is low.
   task automatic send_bits(input logic [23:0] w, input int nbits, input int half);
      for (int i = 0; i < nbits; i++) begin
         scko = 1'b0;
         sdo  = w[23-i];
         step(half);
         scko = 1'b1;
         step(half);
      end
   endtask

   // Final bit of a word, with an optional one-cycle pulse aligned to that word's load edge.
   task automatic last_bit_pulse(input logic b, input bit pr, input bit pc);
      scko = 1'b0;
      sdo  = b;
      step(2);
      scko = 1'b1;
      step(3);
      if (pr) bus.m_ready = 1'b1;
      if (pc) clear_flags = 1'b1;
      step(1);
      if (pr) bus.m_ready = 1'b0;
      if (pc) clear_flags = 1'b0;
      step(2);
   endtask

   // Random frame: nw full words then tbits of a partial word; model records the full words.
   task automatic run_frame(input int half, input int nw, input int tbits);
      logic [23:0] w;
      pulse_cnv();
      for (int k = 0; k < nw; k++) begin
         w = 24'($urandom);
         send_bits(w, 24, half);
         exp_q.push_back(mk(w[23:6], w[5:3], w[2:0], k == 7));
      end
      w = 24'($urandom);
      send_bits(w, tbits, half);
   endtask

   task automatic compare_q(input string name);
      check($sformatf("%s count", name), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s word %0d", name, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_outs_zero(input string name);
      check({name, " m_valid"}, bus.m_valid, 0);
      check({name, " m_data"}, bus.m_data, 0);
      check({name, " m_channel"}, bus.m_channel, 0);
      check({name, " m_softspan"}, bus.m_softspan, 0);
      check({name, " m_last"}, bus.m_last, 0);
      check({name, " overflow"}, overflow, 0);
      check({name, " frame_error"}, frame_error, 0);
   endtask

   // Output monitor: capture accepts, watch hold-while-stalled, count valid gaps.
   initial begin
      out_t prev_o;
      logic prev_v, prev_r, prev_rst;
      prev_o = '0; prev_v = 1'b0; prev_r = 1'b0; prev_rst = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_rst && prev_v && !prev_r && (!bus.m_valid || cur_out() != prev_o)) stab_err++;
         if (watch && !bus.m_valid) vld_low++;
         if (aresetn && bus.m_valid && bus.m_ready) got_q.push_back(cur_out());
         prev_v = bus.m_valid; prev_r = bus.m_ready; prev_o = cur_out(); prev_rst = aresetn;
      end
   end

   // Random consumer, active only during the randomized phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_rdy) bus.m_ready = ($urandom_range(3) != 0);
      end
   end

   initial begin
      vec_t        tbl[8];
      logic [23:0] wa, wb;
      bit          exp_fe, trunc;
      int          half, nw;

      tbl[0] = '{word: {18'h00000, 3'd0, 3'd0}, exp: mk(18'h00000, 3'd0, 3'd0, 1'b0)};
      tbl[1] = '{word: {18'h3FFFF, 3'd1, 3'd7}, exp: mk(18'h3FFFF, 3'd1, 3'd7, 1'b0)};
      tbl[2] = '{word: {18'h15555, 3'd2, 3'd5}, exp: mk(18'h15555, 3'd2, 3'd5, 1'b0)};
      tbl[3] = '{word: {18'h2AAAA, 3'd3, 3'd2}, exp: mk(18'h2AAAA, 3'd3, 3'd2, 1'b0)};
      tbl[4] = '{word: {18'h00001, 3'd4, 3'd1}, exp: mk(18'h00001, 3'd4, 3'd1, 1'b0)};
      tbl[5] = '{word: {18'h20000, 3'd5, 3'd4}, exp: mk(18'h20000, 3'd5, 3'd4, 1'b0)};
      tbl[6] = '{word: {18'h12345, 3'd6, 3'd3}, exp: mk(18'h12345, 3'd6, 3'd3, 1'b0)};
      tbl[7] = '{word: {18'h3C0F0, 3'd7, 3'd6}, exp: mk(18'h3C0F0, 3'd7, 3'd6, 1'b1)};

      // Reset with cnv/scko/sdo high: release must not look like a cnv rise.
      bus.m_ready = 1'b1;
      aresetn = 1'b0; cnv = 1'b1; scko = 1'b1; sdo = 1'b1; clear_flags = 1'b0;
      step(3);
      aresetn = 1'b1;
      step(6);
      check_outs_zero("reset");
      send_bits(24'hFFFFFF, 24, 2);
      step(8);
      check("no frame at release", got_q.size(), 0);
      cnv = 1'b0; scko = 1'b0;
      step(4);

      // Full frame, fixed data, channels 0..7.
      pulse_cnv();
      for (int k = 0; k < 8; k++) begin
         send_bits({18'h2AAAA, 3'(k), 3'b111}, 24, 2);
         exp_q.push_back(mk(18'h2AAAA, 3'(k), 3'b111, k == 7));
      end
      step(8);
      compare_q("full_frame");
      check("full_frame overflow", overflow, 0);
      check("full_frame frame_error", frame_error, 0);

      // Table frame: field slicing on varied words.
      pulse_cnv();
      for (int k = 0; k < 8; k++) send_bits(tbl[k].word, 24, 2);
      step(8);
      check("table count", got_q.size(), 8);
      for (int k = 0; k < 8 && k < got_q.size(); k++)
         check($sformatf("table row %0d", k), got_q[k], tbl[k].exp);
      got_q.delete();

      // Stalled consumer across two words: first held, second dropped.
      do_reset();
      bus.m_ready = 1'b0;
      pulse_cnv();
      send_bits(24'h123457, 24, 2);
      send_bits(24'hFEDCBA, 24, 2);
      step(6);
      check("stall m_valid", bus.m_valid, 1);
      check("stall m_data", bus.m_data, 18'h048D1);
      check("stall m_channel", bus.m_channel, 3'b010);
      check("stall m_softspan", bus.m_softspan, 3'b111);
      check("stall overflow", overflow, 1);
      check("stall frame_error", frame_error, 0);
      bus.m_ready = 1'b1;
      step(2);
      bus.m_ready = 1'b0;
      exp_q.push_back(mk(18'h048D1, 3'b010, 3'b111, 1'b0));
      compare_q("stall accept");

      // Truncated frame then a clean frame.
      do_reset();
      bus.m_ready = 1'b1;
      pulse_cnv();
      send_bits(24'hABCDEF, 10, 2);
      step(2);
      run_frame(2, 8, 0);
      step(8);
      check("trunc frame_error", frame_error, 1);
      check("trunc overflow", overflow, 0);
      compare_q("after_trunc");

      // Accept and load on the same edge.
      do_reset();
      bus.m_ready = 1'b0;
      wa = 24'hA5F30C;
      wb = 24'h3C9E51;
      pulse_cnv();
      send_bits(wa, 24, 2);
      step(5);
      watch = 1'b1;
      send_bits(wb, 23, 2);
      last_bit_pulse(wb[0], 1'b1, 1'b0);
      step(3);
      watch = 1'b0;
      check("swap valid gaps", vld_low, 0);
      check("swap presented", cur_out(), mk(wb[23:6], wb[5:3], wb[2:0], 1'b0));
      check("swap overflow", overflow, 0);
      exp_q.push_back(mk(wa[23:6], wa[5:3], wa[2:0], 1'b0));
      compare_q("swap accepted");

      // Reset mid-word abandons the frame; later scko without cnv is ignored.
      do_reset();
      bus.m_ready = 1'b1;
      pulse_cnv();
      for (int k = 0; k < 3; k++) send_bits(24'h800001 + 24'(k), 24, 2);
      send_bits(24'hFFFFFF, 12, 2);
      aresetn = 1'b0;
      step(1);
      aresetn = 1'b1;
      check_outs_zero("mid_reset");
      got_q.delete();
      send_bits(24'hFFFFFF, 24, 2);
      step(8);
      check("mid_reset no word", got_q.size(), 0);
      check("mid_reset m_valid", bus.m_valid, 0);

      // Flag clear coincident with a new overflow: set wins; a later clear works.
      do_reset();
      bus.m_ready = 1'b0;
      wa = 24'h5A5A5A;
      wb = 24'h0F0F0F;
      pulse_cnv();
      send_bits(wa, 24, 2);
      step(4);
      send_bits(wb, 23, 2);
      last_bit_pulse(wb[0], 1'b0, 1'b1);
      check("clr+set overflow", overflow, 1);
      check("clr+set held word", cur_out(), mk(wa[23:6], wa[5:3], wa[2:0], 1'b0));
      clear_flags = 1'b1;
      step(1);
      clear_flags = 1'b0;
      step(1);
      check("clear overflow", overflow, 0);

      // Randomized frames, random scko rate, random consumer, random truncation.
      do_reset();
      rnd_rdy = 1'b1;
      exp_fe  = 1'b0;
      for (int f = 0; f < 6; f++) begin
         half  = $urandom_range(4, 2);
         trunc = (f < 5) && ($urandom_range(3) == 0);
         nw    = trunc ? $urandom_range(7) : 8;
         if (trunc) exp_fe = 1'b1;
         run_frame(half, nw, trunc ? $urandom_range(23) : 0);
      end
      scko = 1'b0;
      step(10);
      rnd_rdy = 1'b0;
      bus.m_ready = 1'b1;
      step(6);
      compare_q("random");
      check("random overflow", overflow, 0);
      check("random frame_error", frame_error, 32'(exp_fe));

      check("hold while stalled", stab_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
